// File: rtl/pong_pkg.sv
// pong_pkg: shared screen geometry, paddle FSM/direction encodings and the
// paddle centre-x helper used by the pong datapath.
package pong_pkg;

  localparam int VGA_H = 640;  // visible width in pixels
  localparam int VGA_V = 480;  // visible height in pixels

  typedef enum logic [1:0] {IDLE, SLOW, FAST} pad_state_e;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} pad_dir_e;

  // Centre x of paddle i. Even indices sit on the left, odd on the right;
  // each further pair moves lane_gap pixels toward the screen centre.
  function automatic int pad_xc(input int i, input int vga_h, input int edge_off,
                                input int pad_w, input int lane_gap);
    int off;
    off = edge_off + pad_w / 2 + (i / 2) * lane_gap;
    return (i % 2 == 0) ? off : vga_h - off;
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// paddle_axis: one paddle's vertical axis.
//   clk1      system/pixel clock
//   reset     asynchronous active-low reset
//   btn_up_n  active-low up button, asynchronous to clk1 (decreases y)
//   btn_dn_n  active-low down button, asynchronous to clk1 (increases y)
//   tick      one-cycle move strobe from the shared prescaler
//   ypad      registered paddle centre y, clamped to the screen
//   fast      paddle FSM is in FAST
module paddle_axis #(
  parameter int SCREEN_V   = 480,
  parameter int PAD_H      = 80,
  parameter int STEP_SLOW  = 1,
  parameter int STEP_FAST  = 4,
  parameter int HOLD_TICKS = 16
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  input  logic       tick,
  output logic [9:0] ypad,
  output logic       fast
);
  import pong_pkg::*;

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic signed [10:0] YMIN   = 11'(PAD_H / 2);
  localparam logic signed [10:0] YMAX   = 11'(SCREEN_V - PAD_H / 2);
  localparam logic signed [10:0] STEP_S = 11'(STEP_SLOW);
  localparam logic signed [10:0] STEP_F = 11'(STEP_FAST);

  logic [1:0]        up_sync, dn_sync;
  logic              up_s, dn_s;
  pad_dir_e          dir, dir_q, dir_d;
  pad_state_e        state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic signed [10:0] y_cur, y_sum, delta, slow_delta, fast_delta;
  logic [9:0]        y_d;

  assign up_s = ~up_sync[1];
  assign dn_s = ~dn_sync[1];

  // Pressing both buttons cancels out rather than favouring one side.
  always_comb begin
    dir = DIR_NONE;
    if (up_s && !dn_s)      dir = DIR_UP;
    else if (dn_s && !up_s) dir = DIR_DN;
  end

  assign slow_delta = (dir == DIR_UP) ? -STEP_S : STEP_S;
  assign fast_delta = (dir == DIR_UP) ? -STEP_F : STEP_F;
  assign y_cur      = signed'({1'b0, ypad});

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    dir_d   = dir_q;
    delta   = '0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (dir != DIR_NONE) begin
            state_d = SLOW;
            hold_d  = HW'(1);
            dir_d   = dir;
            delta   = slow_delta;
          end
        end
        default: begin
          if (dir == DIR_NONE) begin
            state_d = IDLE;
            hold_d  = '0;
            dir_d   = DIR_NONE;
          end else if (dir != dir_q) begin
            // Reversal restarts acceleration in the new direction.
            state_d = SLOW;
            hold_d  = HW'(1);
            dir_d   = dir;
            delta   = slow_delta;
          end else if (state_q == SLOW) begin
            delta  = slow_delta;
            hold_d = hold_q + 1'b1;
            if (int'(hold_q) + 1 >= HOLD_TICKS) state_d = FAST;
          end else begin
            delta = fast_delta;
          end
        end
      endcase
    end

    // Signed 11-bit sum cannot wrap, so a plain compare saturates correctly.
    y_sum = y_cur + delta;
    if (y_sum < YMIN)      y_d = 10'(YMIN);
    else if (y_sum > YMAX) y_d = 10'(YMAX);
    else                   y_d = 10'(y_sum);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the synchroniser resets to "released".
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      up_sync <= 2'b11;
      dn_sync <= 2'b11;
      state_q <= IDLE;
      hold_q  <= '0;
      dir_q   <= DIR_NONE;
      ypad    <= 10'(SCREEN_V / 2);
    end else begin
      up_sync <= {up_sync[0], btn_up_n};
      dn_sync <= {dn_sync[0], btn_dn_n};
      state_q <= state_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      ypad    <= y_d;
    end
  end

  assign fast = (state_q == FAST);

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: N-paddle controller for the pong datapath.
//   clk1        system/pixel clock
//   reset       asynchronous active-low reset
//   btn_up_n    active-low up buttons, one per paddle
//   btn_dn_n    active-low down buttons, one per paddle
//   x, y        current pixel coordinate
//   ypad        packed paddle centre y, paddle i in [10i+9:10i]
//   xpad        packed paddle centre x, constant per paddle
//   pad_on      pixel (x,y) lies inside paddle i
//   any_pad_on  pixel lies inside any paddle
//   fast        paddle i is moving at the fast rate
module paddle_ctrl #(
  parameter int NUM_PAD    = 2,
  parameter int VGA_H      = pong_pkg::VGA_H,
  parameter int VGA_V      = pong_pkg::VGA_V,
  parameter int PAD_W      = 12,
  parameter int PAD_H      = 80,
  parameter int EDGE_OFF   = 20,
  parameter int LANE_GAP   = 40,
  parameter int TICK_DIV   = 833333,
  parameter int STEP_SLOW  = 1,
  parameter int STEP_FAST  = 4,
  parameter int HOLD_TICKS = 16
) (
  input  logic                  clk1,
  input  logic                  reset,
  input  logic [NUM_PAD-1:0]    btn_up_n,
  input  logic [NUM_PAD-1:0]    btn_dn_n,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  output logic [10*NUM_PAD-1:0] ypad,
  output logic [10*NUM_PAD-1:0] xpad,
  output logic [NUM_PAD-1:0]    pad_on,
  output logic                  any_pad_on,
  output logic [NUM_PAD-1:0]    fast
);
  import pong_pkg::pad_xc;

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] div_q;
  logic          tick;

  // Shared move-rate prescaler: all paddles step on the same edge.
  assign tick = (div_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_PAD; gi++) begin : g_pad
    localparam int XC = pad_xc(gi, VGA_H, EDGE_OFF, PAD_W, LANE_GAP);

    logic [9:0] yc;

    assign xpad[10*gi +: 10] = 10'(XC);
    assign ypad[10*gi +: 10] = yc;

    paddle_axis #(
      .SCREEN_V   (VGA_V),
      .PAD_H      (PAD_H),
      .STEP_SLOW  (STEP_SLOW),
      .STEP_FAST  (STEP_FAST),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_axis (
      .clk1     (clk1),
      .reset    (reset),
      .btn_up_n (btn_up_n[gi]),
      .btn_dn_n (btn_dn_n[gi]),
      .tick     (tick),
      .ypad     (yc),
      .fast     (fast[gi])
    );

    // Half-extents are added to the pixel side instead of subtracted from
    // the centre so the lower bound never underflows.
    assign pad_on[gi] = ({2'b00, x} + 12'(PAD_W / 2) >= 12'(XC)) &&
                        ({2'b00, x} <= 12'(XC + PAD_W / 2)) &&
                        ({2'b00, y} + 12'(PAD_H / 2) >= {2'b00, yc}) &&
                        ({2'b00, y} <= {2'b00, yc} + 12'(PAD_H / 2));
  end

  assign any_pad_on = |pad_on;

endmodule
